// File: rtl/ray_caster.sv
// ray_caster: ray-casting controller for a sparse voxel grid.
//
// It accepts one ray, looks up voxel occupancy at the current position and
// forms the empty cell's AABB from the returned level. It then runs the
// external stepper to just outside that cell, and repeats until it finds a
// hit, leaves the world, or uses up MAX_STEPS stepper runs.
//
// Optional build macro: RAY_CASTER_STATS_EN enables the o_rayCount and
// o_stepCount statistics counters. When it is undefined, both outputs are
// tied to zero.
//
// Ports:
//   i_clock, i_resetN                 clock, async active-low reset
//   i_rayValid/o_rayReady, i_rayQ/V   ray input (origin, signed direction)
//   o_queryValid/i_queryReady         occupancy query, position o_queryPos
//   i_respValid/Occupied/Level        query response (one-cycle pulse)
//   o_stepStart, o_stepQ/V/L/U        stepper start and operands
//   i_stepDone/OutOfBounds/Qp         stepper status and exit position
//   o_hitValid/i_hitReady             result: o_hitPos/Status/Steps
//   o_rayCount, o_stepCount           statistics
//
// Vectors [2:0][WIDTH-1:0] hold x in index 0, y in index 1, z in index 2.
//
// state    | meaning
// IDLE     | ready for a new ray
// QUERY    | occupancy query offered at the current position
// WAITRESP | waiting for the query response
// START    | one-cycle stepper start pulse
// STEP     | waiting for the stepper to finish
// RESULT   | result offered until accepted
module ray_caster #(
  parameter int WIDTH     = 16,
  parameter int LEVEL_W   = 4,
  parameter int MAX_STEPS = 255
) (
  input  logic                  i_clock,
  input  logic                  i_resetN,
  input  logic                  i_rayValid,
  output logic                  o_rayReady,
  input  logic [2:0][WIDTH-1:0] i_rayQ,
  input  logic [2:0][WIDTH-1:0] i_rayV,
  output logic                  o_queryValid,
  input  logic                  i_queryReady,
  output logic [2:0][WIDTH-1:0] o_queryPos,
  input  logic                  i_respValid,
  input  logic                  i_respOccupied,
  input  logic [LEVEL_W-1:0]    i_respLevel,
  output logic                  o_stepStart,
  output logic [2:0][WIDTH-1:0] o_stepQ,
  output logic [2:0][WIDTH-1:0] o_stepV,
  output logic [2:0][WIDTH-1:0] o_stepL,
  output logic [2:0][WIDTH-1:0] o_stepU,
  input  logic                  i_stepDone,
  input  logic                  i_stepOutOfBounds,
  input  logic [2:0][WIDTH-1:0] i_stepQp,
  output logic                  o_hitValid,
  input  logic                  i_hitReady,
  output logic [2:0][WIDTH-1:0] o_hitPos,
  output logic [1:0]            o_hitStatus,
  output logic [7:0]            o_hitSteps,
  output logic [31:0]           o_rayCount,
  output logic [31:0]           o_stepCount
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUERY    = 3'd1,
    WAITRESP = 3'd2,
    START    = 3'd3,
    STEP     = 3'd4,
    RESULT   = 3'd5
  } state_t;

  localparam logic [1:0] ST_HIT   = 2'd0;
  localparam logic [1:0] ST_OOB   = 2'd1;
  localparam logic [1:0] ST_LIMIT = 2'd2;
  localparam logic [7:0] MAX_STEPS_8 = 8'(MAX_STEPS);

  state_t                  r_state, w_state_nxt;
  logic [2:0][WIDTH-1:0]   r_pos, r_dir;
  logic [2:0][WIDTH-1:0]   r_stepQ, r_stepV, r_stepL, r_stepU;
  logic [7:0]              r_steps;
  logic [1:0]              r_status;
  logic [WIDTH-1:0]        w_mask;
  logic [2:0][WIDTH-1:0]   w_lo, w_hi;
  logic                    w_accept, w_resp, w_step_done;
  logic                    w_at_limit;

  // The cell edge is 2^level. The level is clamped to WIDTH-1 so that the
  // mask never covers the whole coordinate range.
  always_comb begin
    w_mask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_mask[b] = (b < WIDTH - 1) && (b < int'(i_respLevel));
    end
    w_lo = '0;
    w_hi = '0;
    for (int i = 0; i < 3; i++) begin
      w_lo[i] = r_pos[i] & ~w_mask;
      w_hi[i] = w_lo[i] | w_mask;
    end
  end

  assign w_at_limit = (r_steps == MAX_STEPS_8);

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_rayReady   = 1'b0;
    o_queryValid = 1'b0;
    o_stepStart  = 1'b0;
    o_hitValid   = 1'b0;
    w_accept     = 1'b0;
    w_resp       = 1'b0;
    w_step_done  = 1'b0;
    case (r_state)
      IDLE: begin
        o_rayReady = 1'b1;
        if (i_rayValid) begin
          w_accept    = 1'b1;
          w_state_nxt = QUERY;
        end
      end
      QUERY: begin
        o_queryValid = 1'b1;
        if (i_queryReady) w_state_nxt = WAITRESP;
      end
      WAITRESP: begin
        if (i_respValid) begin
          w_resp = 1'b1;
          if (i_respOccupied || w_at_limit) w_state_nxt = RESULT;
          else                              w_state_nxt = START;
        end
      end
      START: begin
        o_stepStart = 1'b1;
        w_state_nxt = STEP;
      end
      STEP: begin
        if (i_stepDone) begin
          w_step_done = 1'b1;
          w_state_nxt = i_stepOutOfBounds ? RESULT : QUERY;
        end
      end
      RESULT: begin
        o_hitValid = 1'b1;
        if (i_hitReady) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_pos    <= '0;
      r_dir    <= '0;
      r_stepQ  <= '0;
      r_stepV  <= '0;
      r_stepL  <= '0;
      r_stepU  <= '0;
      r_steps  <= '0;
      r_status <= ST_HIT;
    end else begin
      if (w_accept) begin
        r_pos   <= i_rayQ;
        r_dir   <= i_rayV;
        r_steps <= '0;
      end
      if (w_resp) begin
        if (i_respOccupied) begin
          r_status <= ST_HIT;
        end else if (w_at_limit) begin
          r_status <= ST_LIMIT;
        end else begin
          r_stepL <= w_lo;
          r_stepU <= w_hi;
          r_stepQ <= r_pos;
          r_stepV <= r_dir;
        end
      end
      if (w_step_done) begin
        r_pos <= i_stepQp;
        if (!w_at_limit) r_steps <= r_steps + 8'd1;
        if (i_stepOutOfBounds) r_status <= ST_OOB;
      end
    end
  end

`ifdef RAY_CASTER_STATS_EN
  logic [31:0] r_ray_cnt, r_step_cnt;

  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      r_ray_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      if (w_accept)    r_ray_cnt  <= r_ray_cnt + 32'd1;
      if (w_step_done) r_step_cnt <= r_step_cnt + 32'd1;
    end
  end

  assign o_rayCount  = r_ray_cnt;
  assign o_stepCount = r_step_cnt;
`else
  assign o_rayCount  = '0;
  assign o_stepCount = '0;
`endif

  assign o_queryPos  = r_pos;
  assign o_stepQ     = r_stepQ;
  assign o_stepV     = r_stepV;
  assign o_stepL     = r_stepL;
  assign o_stepU     = r_stepU;
  assign o_hitPos    = r_pos;
  assign o_hitStatus = r_status;
  assign o_hitSteps  = r_steps;

endmodule

// File: tb/tb_ray_caster.sv
// Directed testbench for ray_caster (MAX_STEPS overridden to 3).
// It contains a small environment process that models the occupancy memory
// and the stepper. The stepper advances +x to just past the cell's upper
// bound.
module tb_ray_caster;
  localparam int W = 16;

  logic              clock, resetN;
  logic              rayValid, rayReady;
  logic [2:0][W-1:0] rayQ, rayV;
  logic              queryValid, queryReady;
  logic [2:0][W-1:0] queryPos;
  logic              respValid, respOccupied;
  logic [3:0]        respLevel;
  logic              stepStart;
  logic [2:0][W-1:0] stepQ, stepV, stepL, stepU;
  logic              stepDone, stepOutOfBounds;
  logic [2:0][W-1:0] stepQp;
  logic              hitValid, hitReady;
  logic [2:0][W-1:0] hitPos;
  logic [1:0]        hitStatus;
  logic [7:0]        hitSteps;
  logic [31:0]       rayCount, stepCount;

  ray_caster #(.WIDTH(W), .LEVEL_W(4), .MAX_STEPS(3)) dut (
    .i_clock(clock), .i_resetN(resetN),
    .i_rayValid(rayValid), .o_rayReady(rayReady), .i_rayQ(rayQ), .i_rayV(rayV),
    .o_queryValid(queryValid), .i_queryReady(queryReady), .o_queryPos(queryPos),
    .i_respValid(respValid), .i_respOccupied(respOccupied), .i_respLevel(respLevel),
    .o_stepStart(stepStart), .o_stepQ(stepQ), .o_stepV(stepV), .o_stepL(stepL),
    .o_stepU(stepU), .i_stepDone(stepDone), .i_stepOutOfBounds(stepOutOfBounds),
    .i_stepQp(stepQp), .o_hitValid(hitValid), .i_hitReady(hitReady),
    .o_hitPos(hitPos), .o_hitStatus(hitStatus), .o_hitSteps(hitSteps),
    .o_rayCount(rayCount), .o_stepCount(stepCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // environment state
  bit                occ_tbl [8];
  logic [3:0]        lvl_tbl [8];
  int                idx = 0;
  bit                hs_flag = 0;
  int                qcount = 0;
  int                ss_cnt = 0;
  bit                step_busy = 0;
  int                step_left = 0;
  int                m_lat = 2;
  bit                m_oob = 0;
  bit                stray_en = 0;
  logic [2:0][W-1:0] qp_next, first_L, first_U, first_Q, first_V, last_L;

  function automatic logic [47:0] v3(input int x, input int y, input int z);
    logic [47:0] r;
    r = {z[15:0], y[15:0], x[15:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // query handshake monitor
  initial forever begin
    @(negedge clock);
    if (queryValid && queryReady) begin
      hs_flag = 1;
      qcount++;
    end
  end

  // occupancy responder and stepper model, driven just after each rising edge
  initial forever begin
    @(posedge clock);
    #1;
    respValid    = 1'b0;
    respOccupied = 1'b0;
    if (step_busy) begin
      step_left--;
      if (step_left == 0) begin
        stepDone        = 1'b1;
        stepQp          = qp_next;
        stepOutOfBounds = m_oob;
        step_busy       = 0;
      end else if (stray_en) begin
        respValid    = 1'b1;
        respOccupied = 1'b1;
        stray_en     = 0;
      end
    end
    if (stepStart) begin
      if (ss_cnt == 0) begin
        first_L = stepL; first_U = stepU; first_Q = stepQ; first_V = stepV;
      end
      last_L          = stepL;
      ss_cnt++;
      qp_next         = stepQ;
      qp_next[0]      = stepU[0] + 16'd1;
      stepDone        = 1'b0;
      stepOutOfBounds = 1'b0;
      step_busy       = 1;
      step_left       = m_lat;
    end
    if (hs_flag) begin
      hs_flag      = 0;
      respValid    = 1'b1;
      respOccupied = occ_tbl[idx];
      respLevel    = lvl_tbl[idx];
      idx++;
    end
  end

  // called just after a rising edge; returns just after the acceptance edge
  task automatic send_ray(input logic [47:0] q, input logic [47:0] v);
    bit ok;
    ok = 0;
    idx = 0; qcount = 0; ss_cnt = 0;
    rayQ = q; rayV = v; rayValid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (rayReady) begin ok = 1; break; end
    end
    if (!ok) chk("ray_accept_timeout", 64'(ok), 64'd1);
    @(posedge clock);
    #1;
    rayValid = 1'b0;
  endtask

  // returns at the negedge of the first cycle with hitValid
  task automatic wait_hit(output int lat);
    bit got;
    got = 0;
    lat = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      lat++;
      if (hitValid) begin got = 1; break; end
    end
    if (!got) chk("hit_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    int lat;
    int exp_rays, exp_steps;
    resetN = 1'b0; rayValid = 1'b0; rayQ = '0; rayV = '0;
    queryReady = 1'b1; respValid = 1'b0; respOccupied = 1'b0; respLevel = '0;
    stepDone = 1'b1; stepOutOfBounds = 1'b0; stepQp = '0; hitReady = 1'b1;
    for (int i = 0; i < 8; i++) begin occ_tbl[i] = 0; lvl_tbl[i] = '0; end

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_rayReady", 64'(rayReady), 64'd1);
    chk("rst_queryValid", 64'(queryValid), 64'd0);
    chk("rst_stepStart", 64'(stepStart), 64'd0);
    chk("rst_hitValid", 64'(hitValid), 64'd0);
    chk("rst_vectors", 64'({stepL, stepU, queryPos}), 64'd0);
    chk("rst_hitStatus", 64'(hitStatus), 64'd0);
    chk("rst_counters", {rayCount, stepCount}, 64'd0);
    @(posedge clock); #1; resetN = 1'b1;
    @(posedge clock); #1;

    // 1: hit at origin, minimum latency
    occ_tbl[0] = 1;
    send_ray(v3(100, 100, 100), v3(16'h7FFF, 0, 0));
    wait_hit(lat);
    chk("t1_latency", 64'(lat), 64'd3);
    chk("t1_pos", 64'(hitPos), 64'(v3(100, 100, 100)));
    chk("t1_status", 64'(hitStatus), 64'd0);
    chk("t1_steps", 64'(hitSteps), 64'd0);
    chk("t1_stepstarts", 64'(ss_cnt), 64'd0);
    @(posedge clock); #1;

    // 2: one step then hit
    occ_tbl[0] = 0; lvl_tbl[0] = 4'd3; occ_tbl[1] = 1; m_lat = 2; m_oob = 0;
    send_ray(v3(4, 4, 4), v3(16'h7FFF, 0, 0));
    wait_hit(lat);
    chk("t2_L", 64'(first_L), 64'(v3(0, 0, 0)));
    chk("t2_U", 64'(first_U), 64'(v3(7, 7, 7)));
    chk("t2_Q", 64'(first_Q), 64'(v3(4, 4, 4)));
    chk("t2_V", 64'(first_V), 64'(v3(16'h7FFF, 0, 0)));
    chk("t2_pos", 64'(hitPos), 64'(v3(8, 4, 4)));
    chk("t2_status", 64'(hitStatus), 64'd0);
    chk("t2_steps", 64'(hitSteps), 64'd1);
    chk("t2_stepstarts", 64'(ss_cnt), 64'd1);
    chk("t2_queries", 64'(qcount), 64'd2);
    @(posedge clock); #1;

    // 3: world exit; level 15 is clamped to a 2^15 cell
    occ_tbl[0] = 0; lvl_tbl[0] = 4'd15; occ_tbl[1] = 1; m_oob = 1;
    send_ray(v3(16'hF000, 5, 6), v3(16'h7FFF, 0, 0));
    wait_hit(lat);
    chk("t3_L", 64'(first_L), 64'(v3(16'h8000, 0, 0)));
    chk("t3_U", 64'(first_U), 64'(v3(16'hFFFF, 16'h7FFF, 16'h7FFF)));
    chk("t3_status", 64'(hitStatus), 64'd1);
    chk("t3_pos", 64'(hitPos), 64'(v3(0, 5, 6)));
    chk("t3_steps", 64'(hitSteps), 64'd1);
    chk("t3_queries", 64'(qcount), 64'd1);
    @(posedge clock); #1;

    // 4: step budget (MAX_STEPS=3), level 0 cells
    for (int i = 0; i < 8; i++) begin occ_tbl[i] = 0; lvl_tbl[i] = '0; end
    m_oob = 0;
    send_ray(v3(16'h20, 16'h20, 16'h20), v3(16'h7FFF, 0, 0));
    wait_hit(lat);
    chk("t4_status", 64'(hitStatus), 64'd2);
    chk("t4_steps", 64'(hitSteps), 64'd3);
    chk("t4_stepstarts", 64'(ss_cnt), 64'd3);
    chk("t4_queries", 64'(qcount), 64'd4);
    chk("t4_pos", 64'(hitPos), 64'(v3(16'h23, 16'h20, 16'h20)));
    chk("t4_lastL", 64'(last_L), 64'(v3(16'h22, 16'h20, 16'h20)));
    @(posedge clock); #1;

    // 5: backpressure and a stray response during STEP
    occ_tbl[0] = 0; lvl_tbl[0] = 4'd1; occ_tbl[1] = 1; m_lat = 3;
    queryReady = 1'b0; hitReady = 1'b0; stray_en = 1;
    send_ray(v3(1, 2, 3), v3(0, 16'h7FFF, 0));
    for (int n = 0; n < 5; n++) begin
      @(negedge clock);
      chk("t5_qvalid_held", 64'(queryValid), 64'd1);
      chk("t5_qpos_held", 64'(queryPos), 64'(v3(1, 2, 3)));
    end
    chk("t5_no_query_yet", 64'(qcount), 64'd0);
    @(posedge clock); #1; queryReady = 1'b1;
    wait_hit(lat);
    chk("t5_L", 64'(first_L), 64'(v3(0, 2, 2)));
    chk("t5_U", 64'(first_U), 64'(v3(1, 3, 3)));
    chk("t5_pos", 64'(hitPos), 64'(v3(2, 2, 3)));
    chk("t5_steps", 64'(hitSteps), 64'd1);
    chk("t5_queries", 64'(qcount), 64'd2);
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      chk("t5_hvalid_held", 64'(hitValid), 64'd1);
      chk("t5_hit_held", 64'({hitStatus, hitPos}), 64'({2'd0, v3(2, 2, 3)}));
    end
    @(posedge clock); #1;
    hitReady = 1'b1; idx = 0; qcount = 0; occ_tbl[0] = 1;
    rayQ = v3(9, 9, 9); rayValid = 1'b1;
    @(negedge clock);
    chk("t5_no_accept_in_result", 64'({hitValid, rayReady}), 64'b10);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t5_idle_ready", 64'(rayReady), 64'd1);
    @(posedge clock); #1; rayValid = 1'b0;
    wait_hit(lat);
    chk("t5b_pos", 64'(hitPos), 64'(v3(9, 9, 9)));
    chk("t5b_latency", 64'(lat), 64'd3);
`ifdef RAY_CASTER_STATS_EN
    exp_rays = 6; exp_steps = 6;
`else
    exp_rays = 0; exp_steps = 0;
`endif
    chk("stats_rays", 64'(rayCount), 64'(exp_rays));
    chk("stats_steps", 64'(stepCount), 64'(exp_steps));
    @(posedge clock); #1;

    // 6: reset while the stepper is running
    occ_tbl[0] = 0; lvl_tbl[0] = 4'd2; m_lat = 6;
    send_ray(v3(16'h41, 16'h42, 16'h43), v3(16'h7FFF, 0, 0));
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clock);
        if (stepStart) begin seen = 1; break; end
      end
      chk("t6_stepstart_seen", 64'(seen), 64'd1);
    end
    @(posedge clock); #3;
    chk("t6_L", 64'(stepL), 64'(v3(16'h40, 16'h40, 16'h40)));
    chk("t6_U", 64'(stepU), 64'(v3(16'h43, 16'h43, 16'h43)));
    resetN = 1'b0;
    #1;
    chk("t6_rst_rayReady", 64'(rayReady), 64'd1);
    chk("t6_rst_flags", 64'({queryValid, stepStart, hitValid}), 64'd0);
    chk("t6_rst_stepLU", 64'({stepL, stepU}), 64'd0);
    chk("t6_rst_stepQV", 64'({stepQ, stepV}), 64'd0);
    chk("t6_rst_hit", 64'({hitStatus, hitSteps, hitPos}), 64'd0);
    chk("t6_rst_counters", {rayCount, stepCount}, 64'd0);
    @(posedge clock); #1; resetN = 1'b1;
    @(posedge clock); #1;
    occ_tbl[0] = 1;
    send_ray(v3(7, 7, 7), v3(16'h7FFF, 0, 0));
    wait_hit(lat);
    chk("t7_latency", 64'(lat), 64'd3);
    chk("t7_pos", 64'(hitPos), 64'(v3(7, 7, 7)));
    chk("t7_status_steps", 64'({hitStatus, hitSteps}), 64'd0);
`ifdef RAY_CASTER_STATS_EN
    exp_rays = 1; exp_steps = 0;
`else
    exp_rays = 0; exp_steps = 0;
`endif
    chk("t7_stats_rays", 64'(rayCount), 64'(exp_rays));
    chk("t7_stats_steps", 64'(stepCount), 64'(exp_steps));
    @(posedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
